// File: rtl/msp430_per_arbiter_if.sv
// Bundle of the two requester ports and the shared MSP430 peripheral bus.
// slave  : arbiter view (requests in, acks/read data and peripheral strobes out)
// master : requester/peripheral side view
interface msp430_per_arbiter_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 16
);
   logic              m0_req;
   logic              m0_lock;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_din;
   logic [1:0]        m0_we;
   logic              m0_ack;
   logic [DATA_W-1:0] m0_dout;

   logic              m1_req;
   logic              m1_lock;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_din;
   logic [1:0]        m1_we;
   logic              m1_ack;
   logic [DATA_W-1:0] m1_dout;

   logic              per_en;
   logic [ADDR_W-1:0] per_addr;
   logic [DATA_W-1:0] per_din;
   logic [1:0]        per_we;
   logic [DATA_W-1:0] per_dout;

   modport slave (
      input  m0_req, m0_lock, m0_addr, m0_din, m0_we,
      input  m1_req, m1_lock, m1_addr, m1_din, m1_we,
      input  per_dout,
      output m0_ack, m0_dout, m1_ack, m1_dout,
      output per_en, per_addr, per_din, per_we
   );

   modport master (
      output m0_req, m0_lock, m0_addr, m0_din, m0_we,
      output m1_req, m1_lock, m1_addr, m1_din, m1_we,
      output per_dout,
      input  m0_ack, m0_dout, m1_ack, m1_dout,
      input  per_en, per_addr, per_din, per_we
   );
endinterface

// File: rtl/msp430_per_arbiter.sv
// Two-master arbiter for the MSP430 peripheral bus with bounded burst lock.
// Ties are resolved round-robin; defining PER_ARB_FIXED_PRIO_EN gives every tie to m0.
// All bus-facing outputs are registered and forced to zero outside an access.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | bus free, arbitrate among pending requests
//   S_ACCESS | one-cycle bus access for the owner, ack pulse, read capture
//   S_LOCKED | owner keeps the bus between burst accesses, other ignored
module msp430_per_arbiter #(
   parameter int ADDR_W    = 14,
   parameter int DATA_W    = 16,
   parameter int BURST_MAX = 4
) (
   input  logic                 mclk,
   input  logic                 puc_rst,
   msp430_per_arbiter_if.slave  bus
);
   localparam int               CNT_W    = $clog2(BURST_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_owner;
   logic [CNT_W-1:0]  r_burst_cnt;
   logic              r_m0_ack;
   logic              r_m1_ack;
   logic [DATA_W-1:0] r_m0_dout;
   logic [DATA_W-1:0] r_m1_dout;
   logic              r_per_en;
   logic [ADDR_W-1:0] r_per_addr;
   logic [DATA_W-1:0] r_per_din;
   logic [1:0]        r_per_we;
`ifndef PER_ARB_FIXED_PRIO_EN
   logic              r_last;
`endif

   logic              w_any_req;
   logic              w_winner;
   logic              w_sel;
   logic              w_sel_req;
   logic              w_sel_lock;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_din;
   logic [1:0]        w_sel_we;
   logic              w_issue;

   assign w_any_req = bus.m0_req | bus.m1_req;

`ifdef PER_ARB_FIXED_PRIO_EN
   assign w_winner = ~bus.m0_req;
`else
   // On a tie the master that was not served last wins.
   assign w_winner = (bus.m0_req & bus.m1_req) ? ~r_last : bus.m1_req;
`endif

   // In IDLE the candidate is the arbitration winner, otherwise the current owner.
   assign w_sel      = (r_state == S_IDLE) ? w_winner : r_owner;
   assign w_sel_req  = w_sel ? bus.m1_req  : bus.m0_req;
   assign w_sel_lock = w_sel ? bus.m1_lock : bus.m0_lock;
   assign w_sel_addr = w_sel ? bus.m1_addr : bus.m0_addr;
   assign w_sel_din  = w_sel ? bus.m1_din  : bus.m0_din;
   assign w_sel_we   = w_sel ? bus.m1_we   : bus.m0_we;

   // An access is launched from IDLE on any request or from LOCKED on the owner's request.
   assign w_issue = ((r_state == S_IDLE) & w_any_req) | ((r_state == S_LOCKED) & w_sel_req);

   // Arbitration FSM with registered bus strobes, acks and read-data capture.
   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         r_state     <= S_IDLE;
         r_owner     <= 1'b0;
         r_burst_cnt <= '0;
         r_m0_ack    <= 1'b0;
         r_m1_ack    <= 1'b0;
         r_m0_dout   <= '0;
         r_m1_dout   <= '0;
         r_per_en    <= 1'b0;
         r_per_addr  <= '0;
         r_per_din   <= '0;
         r_per_we    <= 2'b00;
`ifndef PER_ARB_FIXED_PRIO_EN
         r_last      <= 1'b1;
`endif
      end else begin
         r_per_en   <= w_issue;
         r_per_addr <= w_issue ? w_sel_addr : '0;
         r_per_din  <= w_issue ? w_sel_din  : '0;
         r_per_we   <= w_issue ? w_sel_we   : 2'b00;
         r_m0_ack   <= w_issue & ~w_sel;
         r_m1_ack   <= w_issue &  w_sel;

         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_owner     <= w_winner;
                  r_burst_cnt <= '0;
                  r_state     <= S_ACCESS;
               end
            end
            S_ACCESS: begin
`ifndef PER_ARB_FIXED_PRIO_EN
               r_last <= r_owner;
`endif
               if (r_per_we == 2'b00) begin
                  if (r_owner) r_m1_dout <= bus.per_dout;
                  else         r_m0_dout <= bus.per_dout;
               end
               if (w_sel_lock && (r_burst_cnt < CNT_LAST)) begin
                  r_burst_cnt <= r_burst_cnt + CNT_W'(1);
                  r_state     <= S_LOCKED;
               end else begin
                  r_state     <= S_IDLE;
               end
            end
            S_LOCKED: begin
               if (w_sel_req)        r_state <= S_ACCESS;
               else if (!w_sel_lock) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.per_en   = r_per_en;
   assign bus.per_addr = r_per_addr;
   assign bus.per_din  = r_per_din;
   assign bus.per_we   = r_per_we;
   assign bus.m0_ack   = r_m0_ack;
   assign bus.m1_ack   = r_m1_ack;
   assign bus.m0_dout  = r_m0_dout;
   assign bus.m1_dout  = r_m1_dout;
endmodule

// File: tb/tb_msp430_per_arbiter.sv
// Bench for msp430_per_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction-level model.
module tb_msp430_per_arbiter;
   localparam int ADDR_W    = 14;
   localparam int DATA_W    = 16;
   localparam int BURST_MAX = 4;

   logic mclk    = 1'b0;
   logic puc_rst = 1'b0;
   always #5 mclk = ~mclk;

   msp430_per_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   msp430_per_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) dut (
      .mclk    (mclk),
      .puc_rst (puc_rst),
      .bus     (bus)
   );

   logic              req_v  [2];
   logic              lock_v [2];
   logic [ADDR_W-1:0] addr_v [2];
   logic [DATA_W-1:0] din_v  [2];
   logic [1:0]        we_v   [2];
   logic [DATA_W-1:0] pd_rand  = '0;
   logic [DATA_W-1:0] pd_force = '0;
   logic              pd_force_en = 1'b0;
   logic [DATA_W-1:0] w_pd;

   assign w_pd         = pd_force_en ? pd_force : pd_rand;
   assign bus.per_dout = w_pd;
   assign bus.m0_req   = req_v[0];
   assign bus.m0_lock  = lock_v[0];
   assign bus.m0_addr  = addr_v[0];
   assign bus.m0_din   = din_v[0];
   assign bus.m0_we    = we_v[0];
   assign bus.m1_req   = req_v[1];
   assign bus.m1_lock  = lock_v[1];
   assign bus.m1_addr  = addr_v[1];
   assign bus.m1_din   = din_v[1];
   assign bus.m1_we    = we_v[1];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge mclk);
      #1;
   endtask

   task automatic wait_ack(input int m, input int lim, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < lim && !ok; n++) begin
         @(negedge mclk);
         ok = (m == 0) ? bus.m0_ack : bus.m1_ack;
      end
      if (!ok) chk($sformatf("ack_timeout_m%0d", m), 32'd0, 32'd1);
   endtask

   // Peripheral read data changes every cycle, away from the sampling edge.
   always begin
      @(posedge mclk);
      #1;
      pd_rand = 16'($urandom);
   end

   // Transaction-level model: who is accessing the bus this cycle, who holds
   // a burst, how many accesses the holder has done, and the last served master.
   int                m_acc  = -1;
   int                m_hold = -1;
   int                m_done = 0;
   int                m_last = 1;
   logic [ADDR_W-1:0] m_addr = '0;
   logic [DATA_W-1:0] m_din  = '0;
   logic [1:0]        m_we   = '0;
   logic [DATA_W-1:0] m_dout [2] = '{16'h0, 16'h0};

   always @(posedge mclk or posedge puc_rst) begin : model
      int nxt;
      if (puc_rst) begin
         m_acc  = -1;
         m_hold = -1;
         m_done = 0;
         m_last = 1;
         m_dout[0] = '0;
         m_dout[1] = '0;
      end else begin
         nxt = -1;
         if (m_acc >= 0) begin
            m_last = m_acc;
            if (m_we == 2'b00) m_dout[m_acc] = w_pd;
            m_done++;
            m_hold = (lock_v[m_acc] && m_done < BURST_MAX) ? m_acc : -1;
         end else if (m_hold >= 0) begin
            if (req_v[m_hold])        nxt = m_hold;
            else if (!lock_v[m_hold]) m_hold = -1;
         end else if (req_v[0] || req_v[1]) begin
            m_done = 0;
            if (req_v[0] && req_v[1]) begin
`ifdef PER_ARB_FIXED_PRIO_EN
               nxt = 0;
`else
               nxt = 1 - m_last;
`endif
            end else begin
               nxt = req_v[1] ? 1 : 0;
            end
         end
         m_acc = nxt;
         if (nxt >= 0) begin
            m_addr = addr_v[nxt];
            m_din  = din_v[nxt];
            m_we   = we_v[nxt];
         end
      end
   end

   // Compare every DUT output against the model on each falling edge.
   always @(negedge mclk) begin
      chk("per_en",   32'(bus.per_en),   32'(m_acc >= 0));
      chk("per_addr", 32'(bus.per_addr), (m_acc >= 0) ? 32'(m_addr) : 32'd0);
      chk("per_din",  32'(bus.per_din),  (m_acc >= 0) ? 32'(m_din)  : 32'd0);
      chk("per_we",   32'(bus.per_we),   (m_acc >= 0) ? 32'(m_we)   : 32'd0);
      chk("m0_ack",   32'(bus.m0_ack),   32'(m_acc == 0));
      chk("m1_ack",   32'(bus.m1_ack),   32'(m_acc == 1));
      chk("m0_dout",  32'(bus.m0_dout),  32'(m_dout[0]));
      chk("m1_dout",  32'(bus.m1_dout),  32'(m_dout[1]));
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t actual=running required=finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      bit ok;
      bit a [2];
      int got;
      int n;
      int exp_g;
      int m1_cnt;
      bit m0_seen;
      bit a0;
      bit a1;

      for (int i = 0; i < 2; i++) begin
         req_v[i]  = 1'b0;
         lock_v[i] = 1'b0;
         addr_v[i] = '0;
         din_v[i]  = '0;
         we_v[i]   = 2'b00;
      end

      // Reset values
      #2 puc_rst = 1'b1;
      @(negedge mclk);
      chk("rst_per_en",  32'(bus.per_en),  32'd0);
      chk("rst_per_we",  32'(bus.per_we),  32'd0);
      chk("rst_m0_ack",  32'(bus.m0_ack),  32'd0);
      chk("rst_m1_ack",  32'(bus.m1_ack),  32'd0);
      chk("rst_m0_dout", 32'(bus.m0_dout), 32'h0000);
      chk("rst_m1_dout", 32'(bus.m1_dout), 32'h0000);
      repeat (2) tick();
      puc_rst = 1'b0;
      tick();

      // m0 byte write
      addr_v[0] = 14'h0048;
      din_v[0]  = 16'h00A5;
      we_v[0]   = 2'b01;
      req_v[0]  = 1'b1;
      wait_ack(0, 4, ok);
      chk("wr_per_en",   32'(bus.per_en),   32'd1);
      chk("wr_per_addr", 32'(bus.per_addr), 32'h0048);
      chk("wr_per_din",  32'(bus.per_din),  32'h00A5);
      chk("wr_per_we",   32'(bus.per_we),   32'h1);
      chk("wr_m0_ack",   32'(bus.m0_ack),   32'd1);
      chk("wr_m0_dout",  32'(bus.m0_dout),  32'h0000);
      tick();
      req_v[0] = 1'b0;

      // m1 read then m1 write; read data must survive the write
      pd_force    = 16'h3C00;
      pd_force_en = 1'b1;
      addr_v[1]   = 14'h0102;
      din_v[1]    = 16'hFFFF;
      we_v[1]     = 2'b00;
      req_v[1]    = 1'b1;
      wait_ack(1, 4, ok);
      tick();
      req_v[1]    = 1'b0;
      pd_force_en = 1'b0;
      chk("rd_m1_dout", 32'(bus.m1_dout), 32'h3C00);
      tick();
      addr_v[1] = 14'h0104;
      din_v[1]  = 16'h1234;
      we_v[1]   = 2'b11;
      req_v[1]  = 1'b1;
      wait_ack(1, 4, ok);
      tick();
      req_v[1] = 1'b0;
      chk("rd_m1_dout_held", 32'(bus.m1_dout), 32'h3C00);

      // Continuous tie: last served was m1
      for (int i = 0; i < 2; i++) begin
         addr_v[i] = 14'($urandom);
         we_v[i]   = 2'b00;
         lock_v[i] = 1'b0;
         req_v[i]  = 1'b1;
      end
      for (int g = 0; g < 4; g++) begin
         got = -1;
         for (n = 0; n < 6 && got < 0; ) begin
            @(negedge mclk);
            n++;
            if (bus.m0_ack)      got = 0;
            else if (bus.m1_ack) got = 1;
         end
`ifdef PER_ARB_FIXED_PRIO_EN
         exp_g = 0;
`else
         exp_g = g % 2;
`endif
         chk($sformatf("tie_grant_%0d", g), 32'(got), 32'(exp_g));
         chk($sformatf("tie_spacing_%0d", g), 32'(n), 32'd2);
         tick();
         if (got >= 0) addr_v[got] = 14'($urandom);
      end
      req_v[0] = 1'b0;
      req_v[1] = 1'b0;
      tick();
      tick();

      // m1 locked burst while m0 waits
      addr_v[1] = 14'h0300;
      we_v[1]   = 2'b00;
      lock_v[1] = 1'b1;
      req_v[1]  = 1'b1;
      m1_cnt    = 0;
      m0_seen   = 1'b0;
      for (int c = 0; c < 40 && !m0_seen; c++) begin
         @(negedge mclk);
         a0 = bus.m0_ack;
         a1 = bus.m1_ack;
         if (a0) m0_seen = 1'b1;
         else if (a1) m1_cnt++;
         tick();
         if (a1) begin
            addr_v[1] = addr_v[1] + 14'd1;
            if (m1_cnt == 1) begin
               addr_v[0] = 14'h0010;
               we_v[0]   = 2'b00;
               lock_v[0] = 1'b0;
               req_v[0]  = 1'b1;
            end
         end
      end
      chk("burst_m0_served", 32'(m0_seen), 32'd1);
      chk("burst_m1_acks",   32'(m1_cnt),  32'd4);
      req_v[0]  = 1'b0;
      req_v[1]  = 1'b0;
      lock_v[1] = 1'b0;
      tick();

      // Reset during an m0 read access
      addr_v[0] = 14'h0200;
      we_v[0]   = 2'b00;
      lock_v[0] = 1'b0;
      req_v[0]  = 1'b1;
      tick();
      puc_rst = 1'b1;
      @(negedge mclk);
      chk("rstmid_m0_ack",  32'(bus.m0_ack),  32'd0);
      chk("rstmid_per_en",  32'(bus.per_en),  32'd0);
      chk("rstmid_m0_dout", 32'(bus.m0_dout), 32'h0000);
      tick();
      puc_rst = 1'b0;
      @(negedge mclk);
      chk("rstrel_no_ack", 32'(bus.m0_ack), 32'd0);
      @(negedge mclk);
      chk("rstrel_ack",    32'(bus.m0_ack), 32'd1);
      tick();
      req_v[0] = 1'b0;
      tick();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge mclk);
         a[0] = bus.m0_ack;
         a[1] = bus.m1_ack;
         tick();
         for (int i = 0; i < 2; i++) begin
            if (req_v[i] && a[i]) req_v[i] = 1'b0;
            if (!req_v[i]) begin
               if ($urandom_range(0, 99) < 45) begin
                  req_v[i]  = 1'b1;
                  addr_v[i] = 14'($urandom);
                  din_v[i]  = 16'($urandom);
                  we_v[i]   = 2'($urandom_range(0, 3));
                  lock_v[i] = ($urandom_range(0, 2) == 0);
               end else begin
                  lock_v[i] = ($urandom_range(0, 3) == 0);
               end
            end
         end
      end
      req_v[0]  = 1'b0;
      req_v[1]  = 1'b0;
      lock_v[0] = 1'b0;
      lock_v[1] = 1'b0;
      repeat (4) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
